// File: rtl/id_exe_issue_pkg.sv
// rtl/id_exe_issue_pkg.sv - shared types and encodings for the decode/issue stage
package id_exe_issue_pkg;

    typedef enum logic [3:0] {
        EXE_ADD = 4'd0,
        EXE_SUB = 4'd1,
        EXE_AND = 4'd2,
        EXE_OR  = 4'd3,
        EXE_NOR = 4'd4,
        EXE_XOR = 4'd5,
        EXE_SLL = 4'd6,
        EXE_SLA = 4'd7,
        EXE_SRL = 4'd8,
        EXE_SRA = 4'd9,
        EXE_NOP = 4'd15
    } exe_cmd_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [1:0] {
        V2_REG,
        V2_SEXT,
        V2_ZEXT,
        V2_SHAMT
    } val2_sel_t;

    typedef struct packed {
        logic       legal;
        exe_cmd_t   cmd;
        val2_sel_t  val2_sel;
        logic       val1_rt;
        logic       reads_rs;
        logic       reads_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [15:0] imm;
        logic [4:0] shamt;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
    } dec_ctrl_t;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } issue_state_t;

endpackage

// File: rtl/id_exe_issue_decode.sv
// rtl/id_exe_issue_decode.sv - combinational instruction decoder (module id_decode)
module id_decode
    import id_exe_issue_pkg::*;
(
    input  logic [31:0] instr,
    output dec_ctrl_t   ctrl
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        ctrl          = '0;
        ctrl.cmd      = EXE_NOP;
        ctrl.val2_sel = V2_REG;
        ctrl.rs       = instr[25:21];
        ctrl.rt       = instr[20:16];
        ctrl.imm      = instr[15:0];
        ctrl.shamt    = instr[10:6];

        case (op)
            OP_RTYPE: begin
                ctrl.legal    = 1'b1;
                ctrl.rd       = instr[15:11];
                ctrl.reads_rs = 1'b1;
                ctrl.reads_rt = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.cmd = EXE_ADD;
                    FN_SUB:  ctrl.cmd = EXE_SUB;
                    FN_AND:  ctrl.cmd = EXE_AND;
                    FN_OR:   ctrl.cmd = EXE_OR;
                    FN_NOR:  ctrl.cmd = EXE_NOR;
                    FN_XOR:  ctrl.cmd = EXE_XOR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shifts operate on rt by a constant; rs is not a source.
                        ctrl.reads_rs = 1'b0;
                        ctrl.val1_rt  = 1'b1;
                        ctrl.val2_sel = V2_SHAMT;
                        ctrl.cmd      = (funct == FN_SLL) ? EXE_SLL :
                                        (funct == FN_SRL) ? EXE_SRL : EXE_SRA;
                    end
                    default: ctrl.legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.legal    = 1'b1;
                ctrl.rd       = instr[20:16];
                ctrl.reads_rs = 1'b1;
                ctrl.val2_sel = (op == OP_ADDI) ? V2_SEXT : V2_ZEXT;
                ctrl.cmd      = (op == OP_ADDI) ? EXE_ADD :
                                (op == OP_ANDI) ? EXE_AND :
                                (op == OP_ORI)  ? EXE_OR  : EXE_XOR;
            end
            OP_LW: begin
                ctrl.legal    = 1'b1;
                ctrl.rd       = instr[20:16];
                ctrl.reads_rs = 1'b1;
                ctrl.val2_sel = V2_SEXT;
                ctrl.cmd      = EXE_ADD;
                ctrl.mem_read = 1'b1;
            end
            OP_SW: begin
                ctrl.legal     = 1'b1;
                ctrl.reads_rs  = 1'b1;
                ctrl.reads_rt  = 1'b1;
                ctrl.val2_sel  = V2_SEXT;
                ctrl.cmd       = EXE_ADD;
                ctrl.mem_write = 1'b1;
            end
            default: ctrl.legal = 1'b0;
        endcase

        if (!ctrl.legal) begin
            ctrl.cmd      = EXE_NOP;
            ctrl.rd       = 5'd0;
            ctrl.reads_rs = 1'b0;
            ctrl.reads_rt = 1'b0;
            ctrl.val1_rt  = 1'b0;
        end
        ctrl.wb_en = ctrl.legal && !ctrl.mem_write && (ctrl.rd != 5'd0);
    end

endmodule

// File: rtl/id_exe_issue.sv
// rtl/id_exe_issue.sv - decode/issue stage with load-use bubble and single-entry output register
module id_exe_issue
    import id_exe_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            ex_valid,
    input  logic            ex_ready,
    output exe_cmd_t        ex_cmd,
    output logic [XLEN-1:0] ex_val1,
    output logic [XLEN-1:0] ex_val2,
    output logic [XLEN-1:0] ex_st_data,
    output logic [4:0]      ex_rd,
    output logic            ex_wb_en,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_pc,
    input  logic            flush,
    output logic            illegal
);

    typedef struct packed {
        exe_cmd_t        cmd;
        logic [XLEN-1:0] val1;
        logic [XLEN-1:0] val2;
        logic [XLEN-1:0] st_data;
        logic [4:0]      rd;
        logic            wb_en;
        logic            mem_read;
        logic            mem_write;
        logic [XLEN-1:0] pc;
    } ex_payload_t;

    dec_ctrl_t    ctrl;
    ex_payload_t  ex_d, ex_q;
    logic         ex_valid_d, ex_valid_q;
    logic         illegal_d, illegal_q;
    issue_state_t state_d, state_q;
    logic         ld_valid_d, ld_valid_q;
    logic [4:0]   ld_rd_d, ld_rd_q;

    logic            out_free;
    logic            hazard;
    logic            stall;
    logic            fire;
    logic [XLEN-1:0] val1_sel;
    logic [XLEN-1:0] val2_sel;

    id_decode u_decode (
        .instr (if_instr),
        .ctrl  (ctrl)
    );

    assign rf_raddr1 = ctrl.rs;
    assign rf_raddr2 = ctrl.rt;

    // The tracker only ever holds a nonzero LW destination, so r0 never matches.
    assign out_free = !ex_valid_q || ex_ready;
    assign hazard   = ld_valid_q && if_valid &&
                      ((ctrl.reads_rs && (ctrl.rs == ld_rd_q)) ||
                       (ctrl.reads_rt && (ctrl.rt == ld_rd_q)));
    assign stall    = (state_q == ST_RUN) && hazard;
    assign if_ready = out_free && !stall && !flush && !rst;
    assign fire     = if_valid && if_ready;

    always_comb begin
        val1_sel = ctrl.val1_rt ? rf_rdata2 : rf_rdata1;
        case (ctrl.val2_sel)
            V2_SEXT:  val2_sel = {{(XLEN-16){ctrl.imm[15]}}, ctrl.imm};
            V2_ZEXT:  val2_sel = {{(XLEN-16){1'b0}}, ctrl.imm};
            V2_SHAMT: val2_sel = {{(XLEN-5){1'b0}}, ctrl.shamt};
            default:  val2_sel = rf_rdata2;
        endcase
    end

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        illegal_d  = 1'b0;
        state_d    = state_q;
        ld_valid_d = ld_valid_q;
        ld_rd_d    = ld_rd_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            state_d    = ST_RUN;
            ld_valid_d = 1'b0;
        end else begin
            // Tracker advances with the output register so a blocked LW keeps its hazard.
            if (out_free) begin
                ld_valid_d = fire && ctrl.mem_read && ctrl.wb_en;
                ld_rd_d    = ctrl.rt;
            end

            if (fire) begin
                if (ctrl.legal) begin
                    ex_valid_d     = 1'b1;
                    ex_d.cmd       = ctrl.cmd;
                    ex_d.val1      = val1_sel;
                    ex_d.val2      = val2_sel;
                    ex_d.st_data   = rf_rdata2;
                    ex_d.rd        = ctrl.rd;
                    ex_d.wb_en     = ctrl.wb_en;
                    ex_d.mem_read  = ctrl.mem_read;
                    ex_d.mem_write = ctrl.mem_write;
                    ex_d.pc        = if_pc;
                end else begin
                    ex_valid_d = 1'b0;
                    illegal_d  = 1'b1;
                end
            end else if (out_free) begin
                ex_valid_d = 1'b0;
            end

            case (state_q)
                ST_RUN:    if (stall && out_free) state_d = ST_BUBBLE;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '{cmd: EXE_NOP, default: '0};
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            state_q    <= ST_RUN;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= 5'd0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            illegal_q  <= illegal_d;
            state_q    <= state_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_cmd       = ex_q.cmd;
    assign ex_val1      = ex_q.val1;
    assign ex_val2      = ex_q.val2;
    assign ex_st_data   = ex_q.st_data;
    assign ex_rd        = ex_q.rd;
    assign ex_wb_en     = ex_q.wb_en;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_pc        = ex_q.pc;
    assign illegal      = illegal_q;

endmodule

// File: doc/id_exe_issue.md
ID_EXE_ISSUE -- requirements
Module: id_exe_issue

Interface
REQ-001 Parameter XLEN, default 32: datapath width of operands, PC and instruction.
REQ-002 Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 Ports: if_valid in 1, if_ready out 1, if_instr in 32, if_pc in 32 (fetch-side valid/ready).
REQ-004 Ports: rf_raddr1 out 5, rf_raddr2 out 5, rf_rdata1 in 32, rf_rdata2 in 32 (combinational register-file read).
REQ-005 Ports: ex_valid out 1, ex_ready in 1, ex_cmd out 4 (exe_cmd_t), ex_val1 out 32, ex_val2 out 32, ex_st_data out 32, ex_rd out 5, ex_wb_en out 1, ex_mem_read out 1, ex_mem_write out 1, ex_pc out 32.
REQ-006 Ports: flush in 1, squash from branch resolution; illegal out 1, one-cycle pulse.

Function
REQ-007 Decode: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
REQ-008 Decode: op 0x00, funct 0x20/22/24/25/27/26/00/02/03 SHALL give ADD/SUB/AND/OR/NOR/XOR/SLL/SRL/SRA, dest rd, wb_en 1.
REQ-009 Decode: op 0x08 ADDI SHALL give ADD with sign-extended imm; 0x0C/0x0D/0x0E SHALL give AND/OR/XOR with zero-extended imm; dest rt, wb_en 1.
REQ-010 Decode: op 0x23 LW SHALL give ADD with sign-extended imm, mem_read 1, dest rt, wb_en 1.
REQ-011 Decode: op 0x2B SW SHALL give ADD with sign-extended imm, mem_write 1, st_data = rdata(rt), wb_en 0.
REQ-012 Operands: val1 = rdata(rs), val2 = rdata(rt) for register R-type; shifts use val1 = rdata(rt), val2 = zero-extended shamt.
REQ-013 Dest 0: any instruction with destination register 0 SHALL issue with wb_en 0.
REQ-014 Illegal: any other op/funct SHALL be consumed (if_ready handshake completes), produce no ex transfer, and pulse illegal for one cycle.
REQ-015 Output register: ex_* is a single-entry register; ex_* SHALL hold stable while ex_valid=1 and ex_ready=0.
REQ-016 Ready: if_ready SHALL equal (!ex_valid || ex_ready) && !stall && !flush.
REQ-017 Latency: an accepted instruction SHALL appear on ex_* in the next cycle (1-cycle latency); full throughput when no stall.
REQ-018 Load-use hazard: stall=1 when the last issued instruction was LW with nonzero rt, issued in the previous cycle, and the current instruction reads that register as rs or rt.
REQ-019 Bubble: stall SHALL insert exactly one bubble (ex_valid 0 for one cycle); the held instruction issues the following cycle.
REQ-020 FSM: states RUN and BUBBLE; RUN->BUBBLE on stall with output free; BUBBLE->RUN unconditionally; flush in BUBBLE returns to RUN.
REQ-021 Flush: flush SHALL clear ex_valid in the next cycle regardless of ex_ready, accept no input that cycle, and clear the load-use tracker.
REQ-022 Simultaneous: flush has priority over stall, issue and illegal; illegal is suppressed when flush=1.

Reset
REQ-023 In the reset cycle, reset SHALL force ex_valid 0, ex_wb_en/ex_mem_read/ex_mem_write 0, ex_cmd NOP, data outputs 0, illegal 0, FSM RUN, and tracker cleared.
REQ-024 If reset is asserted mid-stall, the held instruction SHALL be dropped; if_ready SHALL be 0 during reset.

Structure
REQ-025 Package: exe_cmd_t (ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SLA=7, SRL=8, SRA=9, NOP=15), opcode/funct constants, and the decoded-control struct SHALL live in the shared package.
REQ-026 Sub-module: pure combinational decoder id_decode SHALL map instruction to control struct; id_exe_issue holds registers, FSM and hazard logic.

Verification
REQ-027 Test: ADDI r1,r0,-1 (0x2001FFFF) -> next cycle ex_cmd ADD, ex_val2 0xFFFFFFFF, ex_rd 1, ex_wb_en 1.
REQ-028 Test: LW r2,4(r1) then ADD r3,r2,r2 back-to-back -> one cycle ex_valid 0, then ADD issues; rf_raddr1 = 2.
REQ-029 Test: ex_ready held 0 for 3 cycles after issuing SUB -> ex_* stable, if_ready 0, then resumes with no loss or duplicate.
REQ-030 Test: instruction 0xFC000000 -> illegal pulses one cycle, no ex_valid, next instruction issues normally.
REQ-031 Test: flush in the same cycle as stall and ex_ready=0 -> ex_valid 0 next cycle, FSM RUN, no bubble pending.
REQ-032 Test: SLL r4,r5,31 -> ex_cmd SLL, ex_val1 = rdata(r5), ex_val2 = 31; ADD r0,r1,r1 -> ex_wb_en 0.
